// File: rtl/upc_checkout_monitor.sv
// Multi-lane UPC checkout monitor: per-lane registered discount/stolen decode,
// per-lane alarm FSM with hold timer, and shared saturating scan/stolen totals.
//
// state | meaning
// IDLE  | no alarm pending for this lane
// ALARM | stolen item seen; alarm driven until ack or hold timer expiry
module upc_checkout_monitor #(
  parameter int NUM_LANES = 4,
  parameter int CODE_W = 3,
  parameter logic [2**CODE_W-1:0] DISCOUNT_MASK = 8'hEC,
  parameter logic [2**CODE_W-1:0] STOLEN_MASK = 8'h31,
  parameter int CNT_W = 8,
  parameter int ALARM_HOLD = 50
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_LANES-1:0]        scan_valid,
  input  logic [NUM_LANES*CODE_W-1:0] scan_code,
  input  logic [NUM_LANES-1:0]        scan_mark,
  input  logic [NUM_LANES-1:0]        alarm_ack,
  input  logic                        clear_totals,
  output logic [NUM_LANES-1:0]        out_valid,
  output logic [NUM_LANES-1:0]        discounted,
  output logic [NUM_LANES-1:0]        stolen,
  output logic [NUM_LANES-1:0]        alarm,
  output logic [CNT_W-1:0]            total_items,
  output logic [CNT_W-1:0]            total_stolen
);

  localparam logic IDLE  = 1'b0;
  localparam logic ALARM = 1'b1;

  localparam int TMR_W = (ALARM_HOLD < 2) ? 1 : $clog2(ALARM_HOLD + 1);
  // Four spare bits absorb up to 8 lanes of increments before clamping.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(ALARM_HOLD);

  logic [NUM_LANES-1:0] state;
  logic [TMR_W-1:0]     timer [NUM_LANES];
  logic [NUM_LANES-1:0] disc_c;
  logic [NUM_LANES-1:0] stl_c;
  logic [NUM_LANES-1:0] stl_scan;
  logic [SUM_W-1:0]     items_sum;
  logic [SUM_W-1:0]     stolen_sum;

  always_comb begin
    disc_c     = '0;
    stl_c      = '0;
    items_sum  = {4'b0000, total_items};
    stolen_sum = {4'b0000, total_stolen};
    for (int l = 0; l < NUM_LANES; l++) begin
      disc_c[l]  = DISCOUNT_MASK[scan_code[l*CODE_W +: CODE_W]];
      stl_c[l]   = ~scan_mark[l] & STOLEN_MASK[scan_code[l*CODE_W +: CODE_W]];
      items_sum  = items_sum + SUM_W'(scan_valid[l]);
      stolen_sum = stolen_sum + SUM_W'(scan_valid[l] & stl_c[l]);
    end
  end

  assign stl_scan = scan_valid & stl_c;
  assign alarm    = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid    <= '0;
      discounted   <= '0;
      stolen       <= '0;
      total_items  <= '0;
      total_stolen <= '0;
      state        <= '0;
      for (int l = 0; l < NUM_LANES; l++) timer[l] <= '0;
    end else begin
      out_valid  <= scan_valid;
      discounted <= scan_valid & disc_c;
      stolen     <= stl_scan;

      if (clear_totals) begin
        total_items  <= '0;
        total_stolen <= '0;
      end else begin
        total_items  <= (items_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : items_sum[CNT_W-1:0];
        total_stolen <= (stolen_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : stolen_sum[CNT_W-1:0];
      end

      for (int l = 0; l < NUM_LANES; l++) begin
        case (state[l])
          IDLE: begin
            if (stl_scan[l]) begin
              state[l] <= ALARM;
              timer[l] <= HOLD_LOAD;
            end
          end
          ALARM: begin
            // A new stolen scan outranks a simultaneous acknowledge.
            if (stl_scan[l]) begin
              timer[l] <= HOLD_LOAD;
            end else if (alarm_ack[l]) begin
              state[l] <= IDLE;
              timer[l] <= '0;
            end else if (ALARM_HOLD > 0) begin
              if (timer[l] == TMR_W'(1)) begin
                state[l] <= IDLE;
                timer[l] <= '0;
              end else begin
                timer[l] <= timer[l] - TMR_W'(1);
              end
            end
          end
          default: state[l] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upc_checkout_monitor.sv
// Self-checking bench for upc_checkout_monitor: two instances (hold=4/CNT_W=4 and
// hold=0/CNT_W=8) share stimulus and are checked against a behavioural model.
module tb_upc_checkout_monitor;
  localparam int NL = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NL-1:0]     scan_valid, scan_mark, alarm_ack;
  logic [NL*CW-1:0]  scan_code;
  logic              clear_totals;

  logic [NL-1:0] a_ov, a_disc, a_stl, a_alarm;
  logic [3:0]    a_items, a_stolen;
  logic [NL-1:0] b_ov, b_disc, b_stl, b_alarm;
  logic [7:0]    b_items, b_stolen;

  upc_checkout_monitor #(.NUM_LANES(NL), .CODE_W(CW), .DISCOUNT_MASK(8'hEC), .STOLEN_MASK(8'h31),
                         .CNT_W(4), .ALARM_HOLD(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_code(scan_code),
    .scan_mark(scan_mark), .alarm_ack(alarm_ack), .clear_totals(clear_totals),
    .out_valid(a_ov), .discounted(a_disc), .stolen(a_stl), .alarm(a_alarm),
    .total_items(a_items), .total_stolen(a_stolen));

  upc_checkout_monitor #(.NUM_LANES(NL), .CODE_W(CW), .DISCOUNT_MASK(8'hEC), .STOLEN_MASK(8'h31),
                         .CNT_W(8), .ALARM_HOLD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_code(scan_code),
    .scan_mark(scan_mark), .alarm_ack(alarm_ack), .clear_totals(clear_totals),
    .out_valid(b_ov), .discounted(b_disc), .stolen(b_stl), .alarm(b_alarm),
    .total_items(b_items), .total_stolen(b_stolen));

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [NL-1:0] m_ov, m_disc, m_stl;
  int            m_rem_a [NL];
  bit            m_on_b  [NL];
  int            m_items_a, m_stolen_a, m_items_b, m_stolen_b;

  // Code bits are {U,P,C}: discounted = P | (U & C); stolen = ~mark & ~P & (~C | U)
  function automatic bit f_disc(logic [2:0] c);
    return c[1] | (c[2] & c[0]);
  endfunction

  function automatic bit f_stl(logic [2:0] c, logic m);
    return !m && !c[1] && (!c[0] || c[2]);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int p, s;
    bit v, st;
    logic [2:0] c;
    if (!reset_n) begin
      m_ov = '0; m_disc = '0; m_stl = '0;
      m_items_a = 0; m_stolen_a = 0; m_items_b = 0; m_stolen_b = 0;
      for (int l = 0; l < NL; l++) begin m_rem_a[l] = 0; m_on_b[l] = 0; end
    end else begin
      p = 0; s = 0;
      for (int l = 0; l < NL; l++) begin
        v  = scan_valid[l];
        c  = scan_code[l*CW +: CW];
        st = v && f_stl(c, scan_mark[l]);
        m_ov[l]   = v;
        m_disc[l] = v && f_disc(c);
        m_stl[l]  = st;
        p += int'(v);
        s += int'(st);
        if (st) m_rem_a[l] = 4;
        else if (alarm_ack[l]) m_rem_a[l] = 0;
        else if (m_rem_a[l] > 0) m_rem_a[l]--;
        if (st) m_on_b[l] = 1;
        else if (alarm_ack[l]) m_on_b[l] = 0;
      end
      if (clear_totals) begin
        m_items_a = 0; m_stolen_a = 0; m_items_b = 0; m_stolen_b = 0;
      end else begin
        m_items_a  = (m_items_a + p > 15) ? 15 : m_items_a + p;
        m_stolen_a = (m_stolen_a + s > 15) ? 15 : m_stolen_a + s;
        m_items_b  = (m_items_b + p > 255) ? 255 : m_items_b + p;
        m_stolen_b = (m_stolen_b + s > 255) ? 255 : m_stolen_b + s;
      end
    end
  endtask

  task automatic step();
    logic [NL-1:0] ea, eb;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      ea[l] = m_rem_a[l] > 0;
      eb[l] = m_on_b[l];
    end
    check("out_valid", a_ov, m_ov);
    check("discounted", a_disc, m_disc);
    check("stolen", a_stl, m_stl);
    check("alarm_a", a_alarm, ea);
    check("items_a", a_items, m_items_a);
    check("stolen_a", a_stolen, m_stolen_a);
    check("alarm_b", b_alarm, eb);
    check("items_b", b_items, m_items_b);
    check("stolen_b", b_stolen, m_stolen_b);
    check("flags_b", {b_ov, b_disc, b_stl}, {m_ov, m_disc, m_stl});
  endtask

  task automatic idle();
    scan_valid = '0; scan_mark = '0; scan_code = '0; alarm_ack = '0; clear_totals = 1'b0;
  endtask

  task automatic scan(int lane, logic [2:0] code, logic mark);
    scan_valid[lane] = 1'b1;
    scan_code[lane*CW +: CW] = code;
    scan_mark[lane] = mark;
  endtask

  initial begin
    bit exp_seq [7];
    reset_n = 1'b0;
    idle();
    for (int l = 0; l < NL; l++) begin m_rem_a[l] = 0; m_on_b[l] = 0; end

    // Reset with scans active
    scan_valid = '1; scan_code = '0; scan_mark = '0; clear_totals = 1'b0;
    @(negedge clk);
    step();
    step();
    check("rst_alarm", a_alarm, 0);
    check("rst_items", a_items, 0);
    reset_n = 1'b1;
    idle();
    scan(0, 3'b000, 1'b0);
    step();
    check("first_items", a_items, 1);
    check("first_stolen", a_stl, 4'b0001);

    // Truth-table sweep on lane 0
    for (int i = 0; i < 16; i++) begin
      idle();
      scan(0, 3'(i), 1'(i >> 3));
      step();
      if (i == 0) check("tt0_disc_stl", {a_disc[0], a_stl[0]}, 2'b01);
    end
    idle();
    alarm_ack = '1;
    step();
    idle();
    repeat (6) step();

    // Alarm hold timing: stolen at "cycle 10", again at "cycle 12"
    exp_seq = '{1, 1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k == 0 || k == 2) scan(1, 3'b000, 1'b0);
      step();
      check("hold_reload", a_alarm[1], exp_seq[k]);
    end
    idle();
    scan(1, 3'b100, 1'b0);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      check("hold_single", a_alarm[1], 1);
      step();
    end
    check("hold_expire", a_alarm[1], 0);

    // Stolen and ack in the same cycle: stolen wins
    idle();
    scan(2, 3'b000, 1'b0);
    step();
    idle();
    scan(2, 3'b000, 1'b0);
    alarm_ack[2] = 1'b1;
    step();
    check("ack_vs_stolen", a_alarm[2], 1);
    idle();
    alarm_ack[2] = 1'b1;
    step();
    check("ack_clears", a_alarm[2], 0);

    // Multi-lane totals after a clear
    idle();
    clear_totals = 1'b1;
    step();
    idle();
    for (int l = 0; l < NL; l++) scan(l, 3'b100, 1'b0);
    step();
    check("ml_items", a_items, 4);
    check("ml_stolen", a_stolen, 4);
    check("ml_alarm", a_alarm, 4'hF);

    // Saturation at 15, then clear with a concurrent scan
    for (int i = 0; i < 20; i++) begin
      idle();
      scan(0, 3'b010, 1'b1);
      step();
    end
    check("sat_items", a_items, 15);
    idle();
    clear_totals = 1'b1;
    scan(3, 3'b000, 1'b0);
    step();
    check("clr_items", a_items, 0);
    check("clr_flags", {a_ov[3], a_stl[3]}, 2'b11);

    // Randomized traffic including occasional reset, clear and ack
    for (int i = 0; i < 300; i++) begin
      scan_valid   = 4'($urandom);
      scan_code    = 12'($urandom);
      scan_mark    = 4'($urandom);
      alarm_ack    = '0;
      for (int l = 0; l < NL; l++) alarm_ack[l] = ($urandom_range(0, 7) == 0);
      clear_totals = ($urandom_range(0, 31) == 0);
      reset_n      = ($urandom_range(0, 99) != 0);
      step();
    end
    reset_n = 1'b1;
    idle();
    alarm_ack = '1;
    step();

    // Hold=0 instance: alarm persists until ack
    idle();
    scan(0, 3'b101, 1'b0);
    step();
    idle();
    repeat (1000) step();
    check("nohold_persist", b_alarm[0], 1);
    check("hold4_expired", a_alarm[0], 0);
    alarm_ack[0] = 1'b1;
    step();
    check("nohold_ack", b_alarm[0], 0);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
